tmp_dig_seq: RTL and testbench

Multi-channel, parametrised successor to the single-channel temperature-sensor sequencer. It drives the switched-capacitor bandgap/diode front end through precharge, big-diode, diode and charge phases. Over OSR iterations it accumulates comparator decisions into an incremental sigma-delta count, and it round-robins across up to N_CH diode channels. Each per-channel result is returned over a valid/ready handshake to the readout logic.

---
 rtl/tmp_dig_seq.sv | 218 +++++++++++++++++++++
 tb/tb_tmp_dig_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmp_dig_seq.sv
// Multi-channel temperature-sensor front-end sequencer with an incremental sigma-delta count.
// Optional comparator chopping in the second half of each conversion: define TMPDIG_CHOP_EN.

module tmp_dig_seq #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned OSR       = 8,
    parameter int unsigned PRE_CYC   = 16,
    parameter int unsigned BIG_CYC   = 6,
    parameter int unsigned DIODE_CYC = 8,
    parameter int unsigned CHG_CYC   = 5,
    localparam int unsigned RES_W    = $clog2(OSR + 1),
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_CH-1:0]  en_mask,
    input  logic             cmp,
    input  logic             result_ready,
    output logic             busy,
    output logic [N_CH-1:0]  ch_sel,
    output logic             preChrg,
    output logic             PI1,
    output logic             PI2,
    output logic             PII1,
    output logic             PII2,
    output logic             PA,
    output logic             PB,
    output logic             PC,
    output logic             PD,
    output logic             s_BG2CMP,
    output logic             cmp_p1,
    output logic             cmp_p2,
    output logic             src_n,
    output logic             snk,
    output logic             chop,
    output logic             result_valid,
    output logic [RES_W-1:0] result,
    output logic [CH_W-1:0]  result_ch
);

    localparam int unsigned MAX_AB  = (PRE_CYC > BIG_CYC) ? PRE_CYC : BIG_CYC;
    localparam int unsigned MAX_CD  = (DIODE_CYC > CHG_CYC) ? DIODE_CYC : CHG_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        StIdle, StPrecharge, StBlankBd, StBigDiode, StBlankD, StDiode, StBlankC, StCharge, StDone
    } state_e;

    state_e            state_q, state_d;
    logic              rst_sync_q;
    logic              start_q, start_d;
    logic [N_CH-1:0]   mask_q, mask_d, ch_onehot, mask_rem;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [RES_W-1:0]  iter_q, iter_d, count_q, count_d;
    logic              dec_q, dec_d;
    logic              chop_phase, cmp_dec;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
        lowest_ch = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_W'(i);
        end
    endfunction

    // Assertion is immediate; release reaches the FSM one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

`ifdef TMPDIG_CHOP_EN
    assign chop_phase = (iter_q >= RES_W'(OSR / 2));
`else
    assign chop_phase = 1'b0;
`endif

    assign cmp_dec   = cmp ^ chop_phase;
    assign ch_onehot = N_CH'(1) << ch_q;
    assign mask_rem  = mask_q & ~ch_onehot;
    // start is registered together with the mask so busy requests are never latched.
    assign start_d   = (state_q == StIdle) && start && !start_q;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            mask_q  <= '0;
            ch_q    <= '0;
            phase_q <= '0;
            iter_q  <= '0;
            count_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            phase_q <= phase_d;
            iter_q  <= iter_d;
            count_q <= count_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        iter_d  = iter_q;
        count_d = count_q;
        dec_d   = dec_q;
        case (state_q)
            StIdle: begin
                if (start_d) begin
                    mask_d = en_mask;
                end else if (start_q && (mask_q != '0)) begin
                    ch_d    = lowest_ch(mask_q);
                    iter_d  = '0;
                    count_d = '0;
                    dec_d   = 1'b0;
                    state_d = StPrecharge;
                end
            end
            StPrecharge: if (phase_q == CNT_W'(PRE_CYC - 1)) state_d = StBlankBd;
            StBlankBd:   state_d = StBigDiode;
            StBigDiode:  if (phase_q == CNT_W'(BIG_CYC - 1)) state_d = StBlankD;
            StBlankD:    state_d = StDiode;
            StDiode:     if (phase_q == CNT_W'(DIODE_CYC - 1)) state_d = StBlankC;
            StBlankC:    state_d = StCharge;
            StCharge: begin
                if (phase_q == CNT_W'(CHG_CYC - 1)) begin
                    dec_d   = cmp_dec;
                    count_d = count_q + RES_W'(cmp_dec);
                    iter_d  = iter_q + RES_W'(1);
                    state_d = (iter_d == RES_W'(OSR)) ? StDone : StBlankBd;
                end
            end
            StDone: begin
                if (result_ready) begin
                    mask_d = mask_rem;
                    if (mask_rem != '0) begin
                        ch_d    = lowest_ch(mask_rem);
                        iter_d  = '0;
                        count_d = '0;
                        dec_d   = 1'b0;
                        state_d = StPrecharge;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        phase_d = (state_d != state_q) ? '0 : phase_q + CNT_W'(1);
    end

    always_comb begin
        preChrg  = 1'b0;
        PI1      = 1'b0;
        PI2      = 1'b0;
        PII1     = 1'b0;
        PII2     = 1'b0;
        PA       = 1'b0;
        PB       = 1'b0;
        PC       = 1'b0;
        PD       = 1'b0;
        s_BG2CMP = 1'b0;
        cmp_p2   = 1'b0;
        src_n    = 1'b1;
        snk      = 1'b0;
        chop     = 1'b0;
        case (state_q)
            StPrecharge: begin
                preChrg  = 1'b1;
                PB       = 1'b1;
                PC       = 1'b1;
                PD       = 1'b1;
                s_BG2CMP = 1'b1;
            end
            StBigDiode: begin
                PI1  = 1'b1;
                PI2  = 1'b1;
                // Feedback pulse from the previous decision; none before the first decision.
                if ((phase_q == '0) && (iter_q != '0)) begin
                    if (dec_q) src_n = 1'b0;
                    else       snk   = 1'b1;
                end
                chop = chop_phase;
            end
            StDiode: begin
                PII1 = 1'b1;
                PII2 = 1'b1;
                chop = chop_phase;
            end
            StCharge: begin
                PA       = 1'b1;
                s_BG2CMP = 1'b1;
                PB       = dec_q;
                PC       = !dec_q;
                cmp_p2   = 1'b1;
                chop     = chop_phase;
            end
            StBlankBd, StBlankD, StBlankC: chop = chop_phase;
            default: ;
        endcase
    end

    assign cmp_p1       = !cmp_p2;
    assign busy         = (state_q != StIdle);
    assign ch_sel       = busy ? ch_onehot : '0;
    assign result_valid = (state_q == StDone);
    assign result       = count_q;
    assign result_ch    = ch_q;

endmodule

// File: tb/tb_tmp_dig_seq.sv
// Directed bench for tmp_dig_seq with short phases (PRE=BIG=DIODE=CHG=4, OSR=8, T=15).

module tb_tmp_dig_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] en_mask = 4'h0;
    logic       cmp = 1'b0;
    logic       result_ready = 1'b0;
    logic       busy, preChrg, PI1, PI2, PII1, PII2, PA, PB, PC, PD, s_BG2CMP;
    logic       cmp_p1, cmp_p2, src_n, snk, chop, result_valid;
    logic [3:0] ch_sel;
    logic [3:0] result;
    logic [1:0] result_ch;

    int tests = 0;
    int fails = 0;

`ifdef TMPDIG_CHOP_EN
    localparam bit CHOP = 1'b1;
`else
    localparam bit CHOP = 1'b0;
`endif
    localparam int LAT = 125;  // 1 + PRE + OSR*T

    tmp_dig_seq #(
        .N_CH(4), .OSR(8), .PRE_CYC(4), .BIG_CYC(4), .DIODE_CYC(4), .CHG_CYC(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .en_mask(en_mask), .cmp(cmp),
        .result_ready(result_ready), .busy(busy), .ch_sel(ch_sel), .preChrg(preChrg),
        .PI1(PI1), .PI2(PI2), .PII1(PII1), .PII2(PII2), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
        .s_BG2CMP(s_BG2CMP), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2), .src_n(src_n), .snk(snk),
        .chop(chop), .result_valid(result_valid), .result(result), .result_ch(result_ch)
    );

    always #5 clk = ~clk;

    function automatic logic any_active();
        return busy | preChrg | PI1 | PI2 | PII1 | PII2 | PA | PB | PC | PD | s_BG2CMP
             | cmp_p2 | snk | chop | result_valid | (|ch_sel) | (|result) | (|result_ch);
    endfunction

    // Reference of one conversion: comparator value per iteration, optional chop inversion.
    task automatic model(input bit toggle, input logic cmp0, output int res, output int srcs,
                         output int snks, output logic [7:0] pb);
        logic d, c;
        d = 1'b0; res = 0; srcs = 0; snks = 0; pb = '0;
        for (int i = 0; i < 8; i++) begin
            pb[i] = d;
            if (i > 0) begin
                if (d) srcs++;
                else   snks++;
            end
            c = (toggle && (i % 2 == 1)) ? !cmp0 : cmp0;
            d = c ^ (CHOP && (i >= 4));
            res += int'(d);
        end
    endtask

    task automatic do_start(input logic [3:0] m);
        @(posedge clk); #1 start = 1'b1; en_mask = m;
        @(posedge clk); #1 start = 1'b0; en_mask = 4'hF;
    endtask

    // Runs until result_valid (bounded), collecting pulse counts and per-iteration PB/chop.
    task automatic run_conv(input bit toggle, input logic [3:0] exp_sel, output int n,
                            output int srcs, output int snks, output logic [7:0] pb,
                            output logic [7:0] chp, output bit sel_bad);
        int it;
        bit prev_p2;
        n = 0; srcs = 0; snks = 0; pb = '0; chp = '0; sel_bad = 0; it = 0; prev_p2 = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (result_valid) break;
            if (busy && ch_sel !== exp_sel) sel_bad = 1;
            if (!src_n) srcs++;
            if (snk) snks++;
            if (cmp_p2 && it < 8) begin
                pb[it]  = PB;
                chp[it] = chp[it] | chop;
            end
            if (prev_p2 && !cmp_p2) begin
                it++;
                if (toggle) cmp = !cmp;
            end
            prev_p2 = cmp_p2;
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        tests++; if (any_active() !== 1'b0) begin fails++; $display("FAIL reset_outs: got active %b expected 0", any_active()); end
        tests++; if ({src_n, cmp_p1} !== 2'b11) begin fails++; $display("FAIL reset_hi: got %b expected 11", {src_n, cmp_p1}); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single;
        int n, srcs, snks, res, esrc, esnk;
        logic [7:0] pb, chp, epb;
        bit sel_bad;
        model(0, 1'b1, res, esrc, esnk, epb);
        cmp = 1'b1; result_ready = 1'b1;
        do_start(4'b0001);
        run_conv(0, 4'b0001, n, srcs, snks, pb, chp, sel_bad);
        tests++; if (n !== LAT) begin fails++; $display("FAIL single_latency: got %0d expected %0d", n, LAT); end
        tests++; if (result !== 4'(res)) begin fails++; $display("FAIL single_result: got %0d expected %0d", result, res); end
        tests++; if (result_ch !== 2'd0) begin fails++; $display("FAIL single_ch: got %0d expected 0", result_ch); end
        tests++; if (ch_sel !== 4'b0001 || sel_bad) begin fails++; $display("FAIL single_chsel: got %b bad %0d expected 0001", ch_sel, sel_bad); end
        tests++; if (chp !== (CHOP ? 8'hF0 : 8'h00)) begin fails++; $display("FAIL chop_iters: got %h expected %h", chp, CHOP ? 8'hF0 : 8'h00); end
        @(posedge clk); #1;
        tests++; if ({busy, result_valid} !== 2'b00) begin fails++; $display("FAIL single_accept: got %b expected 00", {busy, result_valid}); end
    endtask

    task automatic test_two_channels;
        int n, srcs, snks, res, esrc, esnk;
        logic [7:0] pb, chp, epb;
        bit sel_bad;
        model(0, 1'b0, res, esrc, esnk, epb);
        cmp = 1'b0; result_ready = 1'b1;
        do_start(4'b1010);
        run_conv(0, 4'b0010, n, srcs, snks, pb, chp, sel_bad);
        tests++; if (n !== LAT) begin fails++; $display("FAIL two_lat0: got %0d expected %0d", n, LAT); end
        tests++; if ({result_ch, result} !== {2'd1, 4'(res)}) begin fails++; $display("FAIL two_res0: got ch %0d res %0d expected ch 1 res %0d", result_ch, result, res); end
        tests++; if (srcs !== esrc || snks !== esnk) begin fails++; $display("FAIL two_pulses0: got src %0d snk %0d expected %0d %0d", srcs, snks, esrc, esnk); end
        tests++; if (sel_bad) begin fails++; $display("FAIL two_sel0: got bad select expected 0010"); end
        run_conv(0, 4'b1000, n, srcs, snks, pb, chp, sel_bad);
        tests++; if (n !== LAT) begin fails++; $display("FAIL two_lat1: got %0d expected %0d", n, LAT); end
        tests++; if ({result_ch, result} !== {2'd3, 4'(res)}) begin fails++; $display("FAIL two_res1: got ch %0d res %0d expected ch 3 res %0d", result_ch, result, res); end
        tests++; if (srcs !== esrc || snks !== esnk || sel_bad) begin fails++; $display("FAIL two_pulses1: got src %0d snk %0d bad %0d expected %0d %0d", srcs, snks, sel_bad, esrc, esnk); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL two_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_toggle;
        int n, srcs, snks, res, esrc, esnk;
        logic [7:0] pb, chp, epb;
        bit sel_bad;
        model(1, 1'b1, res, esrc, esnk, epb);
        cmp = 1'b1; result_ready = 1'b1;
        do_start(4'b0100);
        run_conv(1, 4'b0100, n, srcs, snks, pb, chp, sel_bad);
        tests++; if ({result_ch, result} !== {2'd2, 4'(res)}) begin fails++; $display("FAIL toggle_res: got ch %0d res %0d expected ch 2 res %0d", result_ch, result, res); end
        tests++; if (pb !== epb) begin fails++; $display("FAIL toggle_pb: got %h expected %h", pb, epb); end
        tests++; if (srcs !== esrc || snks !== esnk) begin fails++; $display("FAIL toggle_pulses: got src %0d snk %0d expected %0d %0d", srcs, snks, esrc, esnk); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n, srcs, snks, res, esrc, esnk;
        logic [7:0] pb, chp, epb;
        bit sel_bad, hold_bad, idle_bad;
        model(0, 1'b1, res, esrc, esnk, epb);
        cmp = 1'b1; result_ready = 1'b0;
        do_start(4'b0011);
        run_conv(0, 4'b0001, n, srcs, snks, pb, chp, sel_bad);
        tests++; if (n !== LAT) begin fails++; $display("FAIL bp_latency: got %0d expected %0d", n, LAT); end
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b1 || result !== 4'(res) || result_ch !== 2'd0 || preChrg !== 1'b0)
                hold_bad = 1;
            start = (i == 5);
            en_mask = (i == 5) ? 4'b1100 : 4'hF;
        end
        tests++; if (hold_bad) begin fails++; $display("FAIL bp_hold: got unstable result expected held %0d ch 0", res); end
        result_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if ({preChrg, result_valid, ch_sel} !== {2'b10, 4'b0010}) begin fails++; $display("FAIL bp_next: got %b expected 100010", {preChrg, result_valid, ch_sel}); end
        run_conv(0, 4'b0010, n, srcs, snks, pb, chp, sel_bad);
        tests++; if (n !== LAT - 1) begin fails++; $display("FAIL bp_lat1: got %0d expected %0d", n, LAT - 1); end
        tests++; if ({result_ch, result} !== {2'd1, 4'(res)}) begin fails++; $display("FAIL bp_res1: got ch %0d res %0d expected ch 1 res %0d", result_ch, result, res); end
        idle_bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) idle_bad = 1;
        end
        tests++; if (idle_bad) begin fails++; $display("FAIL bp_ignore_start: got busy after last result expected idle"); end
    endtask

    task automatic test_mid_reset;
        int n, srcs, snks, res, esrc, esnk, it, guard;
        logic [7:0] pb, chp, epb;
        bit sel_bad, prev_p2;
        model(0, 1'b1, res, esrc, esnk, epb);
        cmp = 1'b1; result_ready = 1'b1;
        do_start(4'b0001);
        it = 0; guard = 0; prev_p2 = 0;
        while (it < 3 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            if (prev_p2 && !cmp_p2) it++;
            prev_p2 = cmp_p2;
        end
        repeat (5) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        tests++; if (any_active() !== 1'b0 || {src_n, cmp_p1} !== 2'b11) begin fails++; $display("FAIL mid_reset_outs: got active %b hi %b expected 0 11", any_active(), {src_n, cmp_p1}); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        do_start(4'b0001);
        run_conv(0, 4'b0001, n, srcs, snks, pb, chp, sel_bad);
        tests++; if (n !== LAT || result !== 4'(res)) begin fails++; $display("FAIL mid_restart: got lat %0d res %0d expected %0d %0d", n, result, LAT, res); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_mask;
        bit bad;
        bad = 0;
        do_start(4'b0000);
        repeat (6) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) bad = 1;
        end
        tests++; if (bad) begin fails++; $display("FAIL zero_mask: got busy expected 0"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_channels();
        test_toggle();
        test_back_to_back();
        test_mid_reset();
        test_zero_mask();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
